// File: rtl/store_drain_buffer.sv
// Committed-store buffer: a circular FIFO drained one write at a time to data memory, plus a load lookup.
// Define STORE_FWD_EN to forward fully covered loads; otherwise every overlapping load stalls.
module store_drain_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enq_valid,
  input  logic [31:0] enq_addr,
  input  logic [31:0] enq_wdata,
  input  logic [3:0]  enq_wmask,
  output logic        enq_ready,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_rmask,
  input  logic        dmem_resp,
  input  logic [31:0] ld_addr,
  input  logic [3:0]  ld_rmask,
  output logic        fwd_hit,
  output logic [31:0] fwd_data,
  output logic        ld_conflict,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  typedef struct packed {
    logic [31:0] store_addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } store_buff_t;

  store_buff_t       entries_q [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [0:0]        state_q, state_d;
  logic              push, pop, busy;
  store_buff_t       headEntry;
  logic              unusedBits;

  assign busy      = (state_q == BUSY);
  assign enq_ready = (count_q != CW'(DEPTH));
  assign push      = enq_valid && enq_ready;
  assign pop       = busy && dmem_resp;
  assign headEntry = entries_q[head_q];
  assign empty     = (count_q == '0) && (state_q == IDLE);

  // The head entry stays in the FIFO while its write is in flight; it only leaves on dmem_resp.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      IDLE:    if (count_q != '0) state_d = BUSY;
      BUSY:    if (dmem_resp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (pop)  head_d = head_q + PW'(1);
    if (push) tail_d = tail_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) entries_q[tail_q] <= '{store_addr: enq_addr, wdata: enq_wdata, wmask: enq_wmask};
    end
  end

  assign dmem_addr  = busy ? {headEntry.store_addr[31:2], 2'b00} : 32'h0;
  assign dmem_wmask = busy ? headEntry.wmask : 4'h0;
  assign dmem_wdata = busy ? headEntry.wdata : 32'h0;
  assign dmem_rmask = 4'h0;

  assign unusedBits = ^{ld_addr[1:0], headEntry.store_addr[1:0]};

  logic          match;
  logic [PW-1:0] lkIdx;
`ifdef STORE_FWD_EN
  logic [31:0]   matchData;
  logic [3:0]    matchMask;
`endif

  // Scan oldest to youngest so the last overlapping entry found is the youngest one.
  always_comb begin
    match = 1'b0;
    lkIdx = '0;
`ifdef STORE_FWD_EN
    matchData = '0;
    matchMask = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      lkIdx = head_q + PW'(k);
      if ((CW'(k) < count_q) &&
          (entries_q[lkIdx].store_addr[31:2] == ld_addr[31:2]) &&
          ((entries_q[lkIdx].wmask & ld_rmask) != 4'h0)) begin
        match = 1'b1;
`ifdef STORE_FWD_EN
        matchData = entries_q[lkIdx].wdata;
        matchMask = entries_q[lkIdx].wmask;
`endif
      end
    end
  end

`ifdef STORE_FWD_EN
  logic covers;
  assign covers      = ((matchMask & ld_rmask) == ld_rmask);
  assign fwd_hit     = match && covers;
  assign fwd_data    = fwd_hit ? matchData : 32'h0;
  assign ld_conflict = match && !covers;
`else
  assign fwd_hit     = 1'b0;
  assign fwd_data    = 32'h0;
  assign ld_conflict = match;
`endif

endmodule

// File: doc/store_drain_buffer.md
STORE_DRAIN_BUFFER -- requirements
Module: store_drain_buffer

Interface
REQ-001 Parameter: DEPTH, default 4, number of committed-store entries (power of two, >=2).
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 enq_valid  input  1  ROB commit presents a store.
REQ-005 enq_addr  input  32  store byte address.
REQ-006 enq_wdata  input  32  store data, already lane-shifted.
REQ-007 enq_wmask  input  4  byte-lane write mask, nonzero.
REQ-008 enq_ready  output  1  buffer can accept a store this cycle.
REQ-009 dmem_addr  output  32  word-aligned write address.
REQ-010 dmem_wmask  output  4  write mask; nonzero means request active.
REQ-011 dmem_wdata  output  32  write data.
REQ-012 dmem_rmask  output  4  tied 4'b0000.
REQ-013 dmem_resp  input  1  memory completed the active write.
REQ-014 ld_addr  input  32  load byte address for forwarding lookup.
REQ-015 ld_rmask  input  4  load byte mask; zero means no lookup.
REQ-016 fwd_hit  output  1  load fully satisfied from buffer.
REQ-017 fwd_data  output  32  forwarded word.
REQ-018 ld_conflict  output  1  load must stall: overlapping store not forwardable.
REQ-019 empty  output  1  no entries held, no write in flight.

Function
REQ-020 Entries SHALL be a circular FIFO of store_buff_t {store_addr, wdata, wmask}, head/tail pointers $clog2(DEPTH) bits wrapping modulo DEPTH, count DEPTH+1 states.
REQ-021 enq_ready SHALL equal (count != DEPTH) from registered count; a pop in the same cycle SHALL NOT enable enqueue when full.
REQ-022 Enqueue SHALL occur on enq_valid && enq_ready, writing tail and incrementing tail.
REQ-023 Drain FSM states IDLE and BUSY; IDLE->BUSY when count>0; BUSY->IDLE on dmem_resp.
REQ-024 In BUSY, dmem_addr={head.store_addr[31:2],2'b00}, dmem_wmask=head.wmask, dmem_wdata=head.wdata, held stable until dmem_resp; in IDLE all three SHALL be zero.
REQ-025 On dmem_resp in BUSY, head entry SHALL be popped (head+1, count-1); next request no earlier than following cycle's BUSY entry.
REQ-026 Latency: store enqueued into empty buffer at edge N SHALL drive dmem_wmask nonzero after edge N+1.
REQ-027 Simultaneous enqueue and pop SHALL leave count unchanged.
REQ-028 dmem_resp in IDLE SHALL be ignored.
REQ-029 Lookup, combinational: match = valid entry (including in-flight head) with store_addr[31:2]==ld_addr[31:2] and (wmask & ld_rmask)!=0; youngest match selected.
REQ-030 empty SHALL equal (count==0) && state==IDLE.
REQ-031 Stores are architecturally committed; the block SHALL have no flush input.

Reset
REQ-032 rst SHALL force state IDLE, head=tail=count=0 and all entries invalid; outputs: enq_ready=1, dmem_*=0, fwd_hit=0, fwd_data=0, ld_conflict=0, empty=1.
REQ-033 rst during BUSY SHALL abandon the in-flight write with no pop; a later dmem_resp SHALL be ignored.

Configuration
REQ-034 Macro STORE_FWD_EN defined: if youngest match's wmask covers ld_rmask, fwd_hit=1, fwd_data=its wdata, ld_conflict=0; if coverage partial, fwd_hit=0, ld_conflict=1.
REQ-035 Macro undefined: fwd_hit=0, fwd_data=0; ld_conflict=1 on any match per REQ-029.

Verification
REQ-036 Empty, enqueue {0x1004, 0xDEADBEEF, 4'hF} -> next cycle dmem_addr=0x1004, dmem_wmask=F; resp after 3 cycles -> pop, empty=1 one cycle later.
REQ-037 Fill DEPTH=4 with resp held low -> enq_ready=0; with enq_valid high during resp cycle -> no enqueue that cycle, enqueue next.
REQ-038 Wrap: 10 back-to-back stores, resp every 2nd cycle -> memory written in order, pointers wrap, no loss or duplication.
REQ-039 STORE_FWD_EN: store {0x2000, 0x11223344, F}, then {0x2000, 0x000000AA, 1}; load 0x2000 rmask 1 -> hit, data 0xAA; rmask F -> conflict=1; undefined -> conflict=1, hit=0 both cases.
REQ-040 rst asserted mid-BUSY with 3 entries -> outputs reset value same cycle; subsequent dmem_resp ignored; empty=1.
